// File: rtl/n64_pkg.sv
// n64_pkg: shared N64 poller types and bit-index constants.
//  state_t        poller FSM states
//  N64_CMD_POLL   host poll command byte
//  R_*            reply bit indices (bit 31 is received first)
//  BTN_*          button-vector indices shared with controller_SM
package n64_pkg;
  typedef enum logic [2:0] {IDLE, TX_BIT, TX_STOP, RX_WAIT, RX_BIT, RX_STOP, UPDATE, FAIL} state_t;
  localparam logic [7:0] N64_CMD_POLL = 8'h01;
  localparam int R_A = 31, R_B = 30, R_Z = 29, R_START = 28;
  localparam int R_DUP = 27, R_DDOWN = 26, R_DLEFT = 25, R_DRIGHT = 24;
  localparam int R_RST = 23, R_L = 21, R_R = 20;
  localparam int R_CUP = 19, R_CDOWN = 18, R_CLEFT = 17, R_CRIGHT = 16;
  localparam int R_X = 8, R_Y = 0;
  localparam int BTN_UP = 0, BTN_DOWN = 1, BTN_LEFT = 2, BTN_RIGHT = 3;
  localparam int BTN_START = 4, BTN_SEL = 5, BTN_A = 6, BTN_B = 7;
  localparam int BTN_X = 8, BTN_Y = 9, BTN_L = 10, BTN_R = 11;
endpackage

// File: rtl/n64_poller_if.sv
// n64_poller_if: pad line and decoded controller outputs of the N64 poller.
//  n64_in       raw data-line level from the pad
//  n64_oe       1 = drive the line low, 0 = release
//  buttons_out  active-high button vector
//  stick_x/y    signed stick values from the last good reply
//  valid        one-cycle pulse when outputs update
//  link_ok      1 after a good reply, 0 after a timeout or reset
// master = poller side, slave = pad/consumer side.
interface n64_poller_if;
  logic n64_in;
  logic n64_oe;
  logic [11:0] buttons_out;
  logic [7:0] stick_x;
  logic [7:0] stick_y;
  logic valid;
  logic link_ok;
  modport master (input n64_in, output n64_oe, buttons_out, stick_x, stick_y, valid, link_ok);
  modport slave (output n64_in, input n64_oe, buttons_out, stick_x, stick_y, valid, link_ok);
endinterface

// File: rtl/n64_line_sync.sv
// n64_line_sync: 2-FF synchronizer for the N64 data line plus registered falling-edge pulse.
//  clk, reset  system clock, asynchronous active-high reset
//  din         raw asynchronous line level
//  level       synchronized line level
//  fall        one-cycle pulse after level goes 1 -> 0
module n64_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic fall
);
  logic s1, s2, s3;
  assign level = s2;
  // Line idles high through the pull-up, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
      fall <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
      fall <= s3 & ~s2;
    end
endmodule

// File: rtl/n64_poller.sv
// n64_poller: polls an N64 controller over its one-wire line and decodes the 32-bit reply.
//  clk    system clock
//  reset  asynchronous active-high reset
//  bus    n64_poller_if.master: n64_in, n64_oe, buttons_out, stick_x, stick_y, valid, link_ok
// Optional macro N64_STICK_DPAD_EN: stick deflection beyond STICK_THRESH also sets d-pad bits.
module n64_poller
  import n64_pkg::*;
#(
  parameter int CLK_HZ = 12_000_000,
  parameter int POLL_PERIOD_US = 16667,
  parameter int TIMEOUT_US = 200,
  parameter int STICK_THRESH = 32
) (
  input logic clk,
  input logic reset,
  n64_poller_if.master bus
);
  localparam int US = CLK_HZ / 1_000_000;
  localparam int CELL = 4 * US;
  localparam int TO = TIMEOUT_US * US;
  localparam int TW = $clog2((TO > CELL ? TO : CELL) + 1);
  localparam int PW = $clog2(POLL_PERIOD_US + 1);
  localparam int QW = $clog2(US);
  localparam logic signed [7:0] TH = 8'(STICK_THRESH);
`ifdef N64_STICK_DPAD_EN
  localparam logic DPAD_EN = 1'b1;
`else
  localparam logic DPAD_EN = 1'b0;
`endif
  state_t state;
  logic [QW-1:0] pre;
  logic [PW-1:0] poll_us;
  logic [TW-1:0] tmr, tmr_nx, tx_low;
  logic [4:0] idx;
  logic [31:0] sh;
  logic [11:0] btn, btn_nx;
  logic [7:0] sx, sy;
  logic oe, vld, lok, seen, lvl, fall, us_tick, poll_due, unused;
  logic signed [7:0] jx, jy;
  n64_line_sync u_sync (.clk(clk), .reset(reset), .din(bus.n64_in), .level(lvl), .fall(fall));
  assign bus.n64_oe = oe;
  assign bus.buttons_out = btn;
  assign bus.stick_x = sx;
  assign bus.stick_y = sy;
  assign bus.valid = vld;
  assign bus.link_ok = lok;
  assign us_tick = pre == QW'(US - 1);
  assign poll_due = poll_us == PW'(POLL_PERIOD_US);
  assign tmr_nx = tmr + 1'b1;
  // Command is sent MSB-first, so cell idx carries bit 7-idx.
  assign tx_low = N64_CMD_POLL[~idx[2:0]] ? TW'(US) : TW'(3 * US);
  assign jx = sh[R_X+:8];
  assign jy = sh[R_Y+:8];
  assign unused = ^{sh[R_RST], sh[22], sh[R_CUP], sh[R_CRIGHT]};
  always_comb begin
    btn_nx = '0;
    btn_nx[BTN_UP] = sh[R_DUP] | (DPAD_EN & (jy >= TH));
    btn_nx[BTN_DOWN] = sh[R_DDOWN] | (DPAD_EN & (jy <= -TH));
    btn_nx[BTN_LEFT] = sh[R_DLEFT] | (DPAD_EN & (jx <= -TH));
    btn_nx[BTN_RIGHT] = sh[R_DRIGHT] | (DPAD_EN & (jx >= TH));
    btn_nx[BTN_START] = sh[R_START];
    btn_nx[BTN_SEL] = sh[R_Z];
    btn_nx[BTN_A] = sh[R_A];
    btn_nx[BTN_B] = sh[R_B];
    btn_nx[BTN_X] = sh[R_CLEFT];
    btn_nx[BTN_Y] = sh[R_CDOWN];
    btn_nx[BTN_L] = sh[R_L];
    btn_nx[BTN_R] = sh[R_R];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      pre <= '0;
      poll_us <= '0;
      tmr <= '0;
      idx <= '0;
      sh <= '0;
      seen <= 1'b0;
      oe <= 1'b0;
      btn <= '0;
      sx <= '0;
      sy <= '0;
      vld <= 1'b0;
      lok <= 1'b0;
    end else begin
      vld <= 1'b0;
      pre <= us_tick ? '0 : pre + 1'b1;
      // Poll timer saturates so an overrunning transfer only delays the next poll.
      if (us_tick && !poll_due) poll_us <= poll_us + 1'b1;
      case (state)
        IDLE:
          if (poll_due) begin
            state <= TX_BIT;
            pre <= '0;
            poll_us <= '0;
            tmr <= '0;
            idx <= '0;
            oe <= 1'b1;
          end
        TX_BIT:
          if (tmr == TW'(CELL - 1)) begin
            tmr <= '0;
            oe <= 1'b1;
            if (idx == 5'd7) state <= TX_STOP;
            else idx <= idx + 1'b1;
          end else begin
            tmr <= tmr_nx;
            oe <= tmr_nx < tx_low;
          end
        TX_STOP:
          if (tmr == TW'(US - 1)) begin
            oe <= 1'b0;
            tmr <= '0;
            state <= RX_WAIT;
          end else tmr <= tmr_nx;
        RX_WAIT:
          if (fall) begin
            state <= RX_BIT;
            tmr <= '0;
            idx <= '0;
          end else if (tmr == TW'(TO - 1)) state <= FAIL;
          else tmr <= tmr_nx;
        RX_BIT: begin
          // tmr counts from the last falling edge; the mid-cell sample happens 2us in.
          if (fall) tmr <= '0;
          else if (tmr == TW'(TO - 1)) state <= FAIL;
          else tmr <= tmr_nx;
          if (!fall && tmr == TW'(2 * US - 1)) begin
            sh <= {sh[30:0], lvl};
            if (idx == 5'd31) begin
              state <= RX_STOP;
              tmr <= '0;
              seen <= 1'b0;
            end else idx <= idx + 1'b1;
          end
        end
        RX_STOP:
          if (seen && lvl) state <= UPDATE;
          else begin
            if (fall) seen <= 1'b1;
            if (tmr == TW'(TO - 1)) state <= FAIL;
            else tmr <= tmr_nx;
          end
        UPDATE: begin
          btn <= btn_nx;
          sx <= sh[R_X+:8];
          sy <= sh[R_Y+:8];
          vld <= 1'b1;
          lok <= 1'b1;
          state <= IDLE;
        end
        FAIL: begin
          btn <= '0;
          lok <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_n64_poller.sv
// tb_n64_poller: directed bench for n64_poller with a behavioural controller on the open-drain line.
module tb_n64_poller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ctrl_low = 1'b0;
  int cyc = 0;
  int vcount = 0;
  int checks = 0;
  int errors = 0;
`ifdef N64_STICK_DPAD_EN
  localparam logic [11:0] EXP_P3 = 12'h62B;
`else
  localparam logic [11:0] EXP_P3 = 12'h621;
`endif
  n64_poller_if bus ();
  assign bus.n64_in = ~(bus.n64_oe | ctrl_low);
  n64_poller #(.CLK_HZ(12_000_000), .POLL_PERIOD_US(1000), .TIMEOUT_US(200), .STICK_THRESH(32)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.valid === 1'b1) vcount <= vcount + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int got, input int lo, input int hi);
    checks++;
    assert (got >= lo && got <= hi) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, got, lo, hi);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_poll(output int t);
    int n = 0;
    while (bus.n64_oe !== 1'b1 && n < 13000) begin
      @(negedge clk);
      n++;
    end
    chk("poll_start", {31'd0, bus.n64_oe}, 32'd1);
    t = cyc;
  endtask

  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (bus.n64_oe === lvl && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic send_reply(input logic [31:0] d, input int nb);
    for (int i = 0; i < nb; i++) begin
      ctrl_low = 1'b1;
      ticks(d[31-i] ? 12 : 36);
      ctrl_low = 1'b0;
      ticks(d[31-i] ? 36 : 12);
    end
    if (nb == 32) begin
      ctrl_low = 1'b1;
      ticks(24);
      ctrl_low = 1'b0;
    end
  endtask

  initial begin
    int t0, ts, tp, lo, hi, vb;
    ticks(3);
    chk("rst_oe", {31'd0, bus.n64_oe}, 32'd0);
    chk("rst_buttons", {20'd0, bus.buttons_out}, 32'd0);
    chk("rst_stick_x", {24'd0, bus.stick_x}, 32'd0);
    chk("rst_stick_y", {24'd0, bus.stick_y}, 32'd0);
    chk("rst_valid", {31'd0, bus.valid}, 32'd0);
    chk("rst_link_ok", {31'd0, bus.link_ok}, 32'd0);
    reset = 1'b0;
    t0 = cyc;
    ticks(11000);
    chk("idle_oe", {31'd0, bus.n64_oe}, 32'd0);
    wait_poll(ts);
    chk_rng("first_poll_delay", ts - t0, 11995, 12005);
    for (int i = 0; i < 8; i++) begin
      run_len(1'b1, lo);
      run_len(1'b0, hi);
      chk($sformatf("cell%0d_low", i), lo, (i == 7) ? 32'd12 : 32'd36);
      chk($sformatf("cell%0d_high", i), hi, (i == 7) ? 32'd36 : 32'd12);
    end
    run_len(1'b1, lo);
    chk("stop_low", lo, 32'd12);
    ticks(24);
    vb = vcount;
    send_reply(32'h8000_7F81, 32);
    ticks(100);
    chk("p1_valid_cnt", vcount - vb, 32'd1);
    chk("p1_buttons", {20'd0, bus.buttons_out}, 32'h040);
    chk("p1_stick_x", {24'd0, bus.stick_x}, 32'h7F);
    chk("p1_stick_y", {24'd0, bus.stick_y}, 32'h81);
    chk("p1_link_ok", {31'd0, bus.link_ok}, 32'd1);
    wait_poll(tp);
    vb = vcount;
    ticks(3000);
    chk("p2_buttons", {20'd0, bus.buttons_out}, 32'd0);
    chk("p2_link_ok", {31'd0, bus.link_ok}, 32'd0);
    chk("p2_valid_cnt", vcount - vb, 32'd0);
    chk("p2_stick_x", {24'd0, bus.stick_x}, 32'h7F);
    chk("p2_stick_y", {24'd0, bus.stick_y}, 32'h81);
    wait_poll(ts);
    chk_rng("p2_p3_period", ts - tp, 11995, 12005);
    ticks(420);
    vb = vcount;
    send_reply(32'h2864_28D0, 32);
    ticks(100);
    chk("p3_valid_cnt", vcount - vb, 32'd1);
    chk("p3_buttons", {20'd0, bus.buttons_out}, {20'd0, EXP_P3});
    chk("p3_stick_x", {24'd0, bus.stick_x}, 32'h28);
    chk("p3_stick_y", {24'd0, bus.stick_y}, 32'hD0);
    chk("p3_link_ok", {31'd0, bus.link_ok}, 32'd1);
    wait_poll(tp);
    ticks(420);
    vb = vcount;
    send_reply(32'hA5A5_A5A5, 20);
    ticks(3000);
    chk("p4_buttons", {20'd0, bus.buttons_out}, 32'd0);
    chk("p4_link_ok", {31'd0, bus.link_ok}, 32'd0);
    chk("p4_valid_cnt", vcount - vb, 32'd0);
    chk("p4_stick_x", {24'd0, bus.stick_x}, 32'h28);
    chk("p4_stick_y", {24'd0, bus.stick_y}, 32'hD0);
    wait_poll(tp);
    ticks(420);
    send_reply(32'h8000_7F81, 10);
    ctrl_low = 1'b1;
    ticks(18);
    #2 reset = 1'b1;
    #1;
    chk("p5_rst_oe", {31'd0, bus.n64_oe}, 32'd0);
    chk("p5_rst_buttons", {20'd0, bus.buttons_out}, 32'd0);
    chk("p5_rst_stick_x", {24'd0, bus.stick_x}, 32'd0);
    chk("p5_rst_stick_y", {24'd0, bus.stick_y}, 32'd0);
    chk("p5_rst_link_ok", {31'd0, bus.link_ok}, 32'd0);
    chk("p5_rst_valid", {31'd0, bus.valid}, 32'd0);
    ctrl_low = 1'b0;
    ticks(2);
    reset = 1'b0;
    t0 = cyc;
    wait_poll(ts);
    chk_rng("post_reset_poll_delay", ts - t0, 11995, 12005);
    ticks(420);
    vb = vcount;
    send_reply(32'h8000_7F81, 32);
    ticks(100);
    chk("p6_valid_cnt", vcount - vb, 32'd1);
    chk("p6_buttons", {20'd0, bus.buttons_out}, 32'h040);
    chk("p6_stick_x", {24'd0, bus.stick_x}, 32'h7F);
    chk("p6_link_ok", {31'd0, bus.link_ok}, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
